// File: rtl/spinn_aer_if_out_dump_pkg.sv
// Shared SpiNNaker link definitions: packet width and the dump FSM state encoding
// used by both directions of the AER interface.
package spinn_aer_if_out_dump_pkg;

   localparam int PKT_BITS = 72;

   typedef enum logic {
      IDLE_ST = 1'b0,
      DUMP_ST = 1'b1
   } dump_state_t;

endpackage

// File: rtl/spinn_aer_if_out_dump_if.sv
// Valid/ready packet channel; the master drives data/vld, the slave drives rdy.
interface spinn_aer_if_out_dump_if;
   import spinn_aer_if_out_dump_pkg::*;

   logic [PKT_BITS-1:0] data;
   logic                vld;
   logic                rdy;

   modport master (output data, output vld, input rdy);
   modport slave  (input data, input vld, output rdy);

endinterface

// File: rtl/spinn_aer_if_skid_buf.sv
// Two-entry valid/ready buffer with a registered ready, a synchronous flush and an
// occupancy output. The head entry drives the output until it is taken.
module spinn_aer_if_skid_buf #(
   parameter int W = 72
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic [W-1:0] in_data,
   input  logic         in_vld,
   output logic         in_rdy,
   output logic [W-1:0] out_data,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [1:0]   occupancy
);

   logic [W-1:0] mem_reg [2];
   logic         rd_ptr_reg;
   logic         wr_ptr_reg;
   logic [1:0]   count_reg;
   logic [1:0]   count_next;
   logic         rdy_reg;
   logic         push;
   logic         pop;

   assign push      = in_vld && rdy_reg;
   assign pop       = out_vld && out_rdy;
   assign out_vld   = (count_reg != 2'd0);
   assign out_data  = mem_reg[rd_ptr_reg];
   assign in_rdy    = rdy_reg;
   assign occupancy = count_reg;

   always_comb begin
      count_next = count_reg;
      if (flush)
         count_next = 2'd0;
      else if (push && !pop)
         count_next = count_reg + 2'd1;
      else if (pop && !push)
         count_next = count_reg - 2'd1;
   end

   // Ready is computed from the next occupancy so it is a clean register output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_reg    <= '{default: '0};
         rd_ptr_reg <= 1'b0;
         wr_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
         rdy_reg    <= 1'b0;
      end else begin
         count_reg <= count_next;
         rdy_reg   <= (count_next != 2'd2);
         if (flush) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
         end else begin
            if (push) begin
               mem_reg[wr_ptr_reg] <= in_data;
               wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop)
               rd_ptr_reg <= ~rd_ptr_reg;
         end
      end
   end

endmodule

// File: rtl/spinn_aer_if_out_dump.sv
// SpiNNaker->AER output dump controller: forwards packets through a skid buffer and,
// after a sustained peripheral stall, discards and counts traffic until it recovers.
module spinn_aer_if_out_dump
   import spinn_aer_if_out_dump_pkg::*;
#(
   parameter int DUMP_CNT = 128,
   parameter int CNT_BITS = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    go,
   input  logic                    drop_clr,
   output logic                    dump_mode,
   output logic [CNT_BITS-1:0]     drop_cnt,
   spinn_aer_if_out_dump_if.slave  spkt,
   spinn_aer_if_out_dump_if.master opkt
);

   localparam int CTR_BITS = $clog2(DUMP_CNT + 1);
   localparam logic [CTR_BITS-1:0] CTR_LOAD = CTR_BITS'(DUMP_CNT);

   dump_state_t          state_reg, state_next;
   logic [CTR_BITS-1:0]  busy_ctr_reg, busy_ctr_next;
   logic [CNT_BITS-1:0]  drop_cnt_reg, drop_cnt_next;
   logic [CNT_BITS:0]    drop_sum;
   logic                 live_reg;
   logic                 busy;
   logic                 dump_go;
   logic                 buf_flush;
   logic                 buf_in_vld;
   logic                 buf_in_rdy;
   logic                 buf_out_vld;
   logic [PKT_BITS-1:0]  buf_out_data;
   logic [1:0]           buf_occ;
   logic [1:0]           drops;

   spinn_aer_if_skid_buf #(.W(PKT_BITS)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (buf_flush),
      .in_data   (spkt.data),
      .in_vld    (buf_in_vld),
      .in_rdy    (buf_in_rdy),
      .out_data  (buf_out_data),
      .out_vld   (buf_out_vld),
      .out_rdy   (opkt.rdy),
      .occupancy (buf_occ)
   );

   assign opkt.vld  = buf_out_vld && (state_reg == IDLE_ST);
   assign opkt.data = buf_out_data;
   assign busy      = opkt.vld && !opkt.rdy;
   assign dump_go   = (state_reg == IDLE_ST) && busy && (busy_ctr_reg == '0);
   assign dump_mode = (state_reg == DUMP_ST);
   assign drop_cnt  = drop_cnt_reg;

   always_comb begin
      busy_ctr_next = busy_ctr_reg;
      if (!busy)
         busy_ctr_next = CTR_LOAD;
      else if (busy_ctr_reg != '0)
         busy_ctr_next = busy_ctr_reg - 1'b1;
   end

   // Accept path: buffered forward, accept-and-drop, or blocked on the dump edge.
   always_comb begin
      state_next = state_reg;
      spkt.rdy   = 1'b0;
      buf_in_vld = 1'b0;
      buf_flush  = 1'b0;
      drops      = 2'd0;
      case (state_reg)
         IDLE_ST: begin
            if (dump_go) begin
               state_next = DUMP_ST;
               buf_flush  = 1'b1;
               drops      = buf_occ;
            end else if (!go) begin
               spkt.rdy = live_reg;
               drops    = {1'b0, spkt.vld && live_reg};
            end else begin
               spkt.rdy   = buf_in_rdy;
               buf_in_vld = spkt.vld;
            end
         end
         DUMP_ST: begin
            spkt.rdy = 1'b1;
            drops    = {1'b0, spkt.vld};
            if (opkt.rdy)
               state_next = IDLE_ST;
         end
         default: state_next = IDLE_ST;
      endcase
   end

   assign drop_sum = {1'b0, drop_cnt_reg} + (CNT_BITS + 1)'(drops);

   always_comb begin
      drop_cnt_next = drop_sum[CNT_BITS-1:0];
      if (drop_clr)
         drop_cnt_next = CNT_BITS'(drops);
      else if (drop_sum[CNT_BITS])
         drop_cnt_next = '1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE_ST;
         busy_ctr_reg <= CTR_LOAD;
         drop_cnt_reg <= '0;
         live_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         busy_ctr_reg <= busy_ctr_next;
         drop_cnt_reg <= drop_cnt_next;
         live_reg     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spinn_aer_if_out_dump.sv
// Directed bench for the output dump controller with a packet scoreboard on opkt.
module tb_spinn_aer_if_out_dump;
   import spinn_aer_if_out_dump_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b1;
   logic        drop_clr = 1'b0;
   logic        dump_mode;
   logic [15:0] drop_cnt;
   logic        sat_go = 1'b0;
   logic        sat_dump_mode;
   logic [3:0]  sat_drop_cnt;

   int n_assert = 0;
   int n_fail   = 0;
   logic [PKT_BITS-1:0] exp_q [$];
   logic [PKT_BITS-1:0] exp_d;

   spinn_aer_if_out_dump_if spkt_if ();
   spinn_aer_if_out_dump_if opkt_if ();
   spinn_aer_if_out_dump_if sat_spkt_if ();
   spinn_aer_if_out_dump_if sat_opkt_if ();

   spinn_aer_if_out_dump #(.DUMP_CNT(128), .CNT_BITS(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .go        (go),
      .drop_clr  (drop_clr),
      .dump_mode (dump_mode),
      .drop_cnt  (drop_cnt),
      .spkt      (spkt_if.slave),
      .opkt      (opkt_if.master)
   );

   // Narrow counter instance to exercise saturation in a handful of cycles.
   spinn_aer_if_out_dump #(.DUMP_CNT(4), .CNT_BITS(4)) sat_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .go        (sat_go),
      .drop_clr  (1'b0),
      .dump_mode (sat_dump_mode),
      .drop_cnt  (sat_drop_cnt),
      .spkt      (sat_spkt_if.slave),
      .opkt      (sat_opkt_if.master)
   );

   always #5 clk = ~clk;

   function automatic logic [PKT_BITS-1:0] mk(input int i);
      return {8'(i), 32'hDEAD_0000 | 32'(i), 32'(i * 7 + 3)};
   endfunction

   task automatic chk(input string tag, input logic [PKT_BITS-1:0] obs,
                      input logic [PKT_BITS-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every opkt handshake must match the oldest expected packet.
   always @(negedge clk) begin
      if (opkt_if.vld === 1'b1 && opkt_if.rdy === 1'b1) begin
         n_assert++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_extra: observed %0h expected none", opkt_if.data);
         end
         if (exp_q.size() != 0) begin
            exp_d = exp_q.pop_front();
            chk("sb_data", opkt_if.data, exp_d);
            $display("opkt transfer data=%0h", opkt_if.data);
         end
      end
   end

   initial begin
      spkt_if.data = '0;
      spkt_if.vld  = 1'b0;
      opkt_if.rdy  = 1'b1;
      sat_spkt_if.data = '0;
      sat_spkt_if.vld  = 1'b0;
      sat_opkt_if.rdy  = 1'b1;

      // Reset values
      #2;
      chk("rst_dump_mode", dump_mode, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_spkt_rdy", spkt_if.rdy, 0);
      chk("rst_opkt_vld", opkt_if.vld, 0);
      chk("rst_opkt_data", opkt_if.data, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("rel_spkt_rdy", spkt_if.rdy, 1);

      // Streaming at full rate with one-cycle latency
      for (int i = 0; i < 10; i++) begin
         spkt_if.data = mk(i);
         spkt_if.vld  = 1'b1;
         #1;
         chk("strm_rdy", spkt_if.rdy, 1);
         exp_q.push_back(mk(i));
         step();
         chk("strm_lat_vld", opkt_if.vld, 1);
         chk("strm_lat_data", opkt_if.data, mk(i));
         chk("strm_dump", dump_mode, 0);
      end
      spkt_if.vld = 1'b0;
      step();
      chk("strm_drop_cnt", drop_cnt, 0);

      // Near-miss: opkt_rdy rises in the last stall cycle before a dump
      opkt_if.rdy  = 1'b0;
      spkt_if.data = mk(20);
      spkt_if.vld  = 1'b1;
      #1;
      chk("nm_rdy", spkt_if.rdy, 1);
      exp_q.push_back(mk(20));
      step();
      spkt_if.vld = 1'b0;
      for (int k = 1; k <= 128; k++) step();
      chk("nm_dump_t128", dump_mode, 0);
      opkt_if.rdy = 1'b1;
      step();
      chk("nm_dump_t129", dump_mode, 0);
      chk("nm_opkt_vld", opkt_if.vld, 0);
      chk("nm_busy_ctr", dut.busy_ctr_reg, 128);

      // Timeout with two buffered packets
      opkt_if.rdy  = 1'b0;
      spkt_if.data = mk(30);
      spkt_if.vld  = 1'b1;
      #1;
      chk("to_rdy_a", spkt_if.rdy, 1);
      exp_q.push_back(mk(30));
      step();
      spkt_if.data = mk(31);
      #1;
      chk("to_rdy_b", spkt_if.rdy, 1);
      exp_q.push_back(mk(31));
      step();
      spkt_if.vld = 1'b0;
      for (int k = 2; k <= 128; k++) step();
      chk("to_dump_t128", dump_mode, 0);
      chk("to_opkt_vld_t128", opkt_if.vld, 1);
      step();
      exp_q.delete();
      chk("to_dump_t129", dump_mode, 1);
      chk("to_drop_cnt", drop_cnt, 2);
      chk("to_opkt_vld", opkt_if.vld, 0);

      // Traffic accepted and dropped while dumping
      for (int i = 0; i < 5; i++) begin
         spkt_if.data = mk(40 + i);
         spkt_if.vld  = 1'b1;
         #1;
         chk("dmp_rdy", spkt_if.rdy, 1);
         step();
      end
      spkt_if.vld = 1'b0;
      chk("dmp_drop_cnt", drop_cnt, 7);
      chk("dmp_mode", dump_mode, 1);
      chk("dmp_opkt_vld", opkt_if.vld, 0);

      // Recovery when the peripheral becomes ready
      opkt_if.rdy = 1'b1;
      step();
      chk("rec_dump", dump_mode, 0);
      spkt_if.data = mk(50);
      spkt_if.vld  = 1'b1;
      #1;
      chk("rec_rdy", spkt_if.rdy, 1);
      exp_q.push_back(mk(50));
      step();
      spkt_if.vld = 1'b0;
      chk("rec_lat_vld", opkt_if.vld, 1);
      chk("rec_lat_data", opkt_if.data, mk(50));
      step();

      // go=0: buffered packet drains, incoming packets are dropped
      opkt_if.rdy  = 1'b0;
      drop_clr     = 1'b1;
      spkt_if.data = mk(60);
      spkt_if.vld  = 1'b1;
      #1;
      chk("go_rdy_f", spkt_if.rdy, 1);
      exp_q.push_back(mk(60));
      step();
      drop_clr = 1'b0;
      chk("go_clr", drop_cnt, 0);
      go = 1'b0;
      opkt_if.rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         spkt_if.data = mk(61 + i);
         #1;
         chk("go0_rdy", spkt_if.rdy, 1);
         step();
      end
      spkt_if.vld = 1'b0;
      chk("go0_drop_cnt", drop_cnt, 3);
      chk("go0_opkt_vld", opkt_if.vld, 0);
      drop_clr     = 1'b1;
      spkt_if.data = mk(64);
      spkt_if.vld  = 1'b1;
      step();
      drop_clr    = 1'b0;
      spkt_if.vld = 1'b0;
      go          = 1'b1;
      chk("clr_with_drop", drop_cnt, 1);

      // Asynchronous reset with a full buffer
      opkt_if.rdy  = 1'b0;
      spkt_if.data = mk(70);
      spkt_if.vld  = 1'b1;
      step();
      spkt_if.data = mk(71);
      step();
      spkt_if.vld = 1'b0;
      chk("pre_rst_vld", opkt_if.vld, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_opkt_vld", opkt_if.vld, 0);
      chk("arst_opkt_data", opkt_if.data, 0);
      chk("arst_spkt_rdy", spkt_if.rdy, 0);
      chk("arst_dump", dump_mode, 0);
      chk("arst_drop_cnt", drop_cnt, 0);
      step();
      rst_n = 1'b1;
      opkt_if.rdy = 1'b1;
      step();
      chk("post_rst_rdy", spkt_if.rdy, 1);
      spkt_if.data = mk(80);
      spkt_if.vld  = 1'b1;
      exp_q.push_back(mk(80));
      step();
      spkt_if.vld = 1'b0;
      chk("post_rst_vld", opkt_if.vld, 1);
      chk("post_rst_data", opkt_if.data, mk(80));
      step();

      // Saturation on the narrow instance
      sat_spkt_if.vld = 1'b1;
      for (int i = 0; i < 14; i++) step();
      sat_spkt_if.vld = 1'b0;
      chk("sat_pre", sat_drop_cnt, 4'hE);
      sat_spkt_if.vld = 1'b1;
      for (int i = 0; i < 3; i++) step();
      sat_spkt_if.vld = 1'b0;
      chk("sat_hold", sat_drop_cnt, 4'hF);

      step();
      chk("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
